nios2_hex_sched: RTL and testbench

- Avalon-MM slave controller that owns all six DE10 seven-segment digits (HEX0..HEX5) in place of six single-digit PIOs.
- Holds a 24-bit nibble value and decodes each nibble to active-low segments.
- Sequences the display with a programmable tick: per-digit blanking, per-digit blinking, and left/right scrolling.
- Sits on the Nios II data master; software writes a value once and the block runs the display autonomously.

---
 rtl/nios2_hex_pkg.sv | 21 ++
 rtl/nios2_hex_seg_decode.sv | 28 ++
 rtl/nios2_hex_sched.sv | 157 +++++++++++++++
 tb/tb_nios2_hex_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_hex_pkg.sv
// nios2_hex_pkg: register map, CTRL/MASK bit positions and segment constants
// shared by the nios2_hex_sched display controller.
package nios2_hex_pkg;

    typedef enum logic [1:0] {
        ADDR_VALUE  = 2'd0,
        ADDR_MASK   = 2'd1,
        ADDR_CTRL   = 2'd2,
        ADDR_PERIOD = 2'd3
    } reg_addr_e;

    localparam int CTRL_SCROLL = 0;
    localparam int CTRL_DIR    = 1;
    localparam int CTRL_BLINK  = 2;
    localparam int CTRL_IRQ_EN = 8;
    localparam int CTRL_WRAP   = 16;
    localparam int MASK_BLINK  = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/nios2_hex_seg_decode.sv
// nios2_hex_seg_decode: hex nibble to active-low seven-segment pattern (g..a).
module nios2_hex_seg_decode (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/nios2_hex_sched.sv
// nios2_hex_sched: Avalon-MM controller running all six HEX digits with blank,
// blink and scroll sequencing. Define NIOS2_HEX_SCHED_IRQ_EN for the scroll-wrap interrupt.
module nios2_hex_sched
    import nios2_hex_pkg::*;
#(
    parameter int          DIGITS     = 6,
    parameter logic [23:0] PERIOD_RST = 24'd5000000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [7*DIGITS-1:0] hex_out,
    output logic                irq
);

    localparam int             VW      = 4 * DIGITS;
    localparam int             RW      = $clog2(DIGITS);
    localparam logic [RW-1:0]  ROT_MAX = RW'(DIGITS - 1);

    reg_addr_e addr;
    logic      wr, wr_value, wr_mask, wr_ctrl, wr_period;

    assign addr      = reg_addr_e'(address);
    assign wr        = chipselect && !write_n;
    assign wr_value  = wr && (addr == ADDR_VALUE);
    assign wr_mask   = wr && (addr == ADDR_MASK);
    assign wr_ctrl   = wr && (addr == ADDR_CTRL);
    assign wr_period = wr && (addr == ADDR_PERIOD);

    logic [VW-1:0]       value_q, value_d;
    logic [DIGITS-1:0]   blank_q, blank_d, blink_q, blink_d;
    logic                scroll_q, scroll_d, dir_q, dir_d, blink_en_q, blink_en_d;
    logic [23:0]         period_q, period_d, cnt_q, cnt_d;
    logic [RW-1:0]       rot_q, rot_d, rot_step;
    logic                phase_q, phase_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;
    logic                tick, scroll_clr;
    logic [6:0]          seg [DIGITS];
    logic [31:0]         mask_rd, ctrl_rd;
    logic                wrap_q, irq_en_q;
    logic                unused_wdata;

    assign unused_wdata = ^writedata[31:24];

    // Digit i shows nibble (i + rot) mod DIGITS of VALUE.
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic [RW:0] sum, sel;
        assign sum = (RW + 1)'(i) + {1'b0, rot_q};
        assign sel = (sum >= (RW + 1)'(DIGITS)) ? sum - (RW + 1)'(DIGITS) : sum;
        nios2_hex_seg_decode u_dec (
            .nibble (value_q[4*sel +: 4]),
            .seg    (seg[i])
        );
    end

    always_comb begin
        tick       = (period_q != '0) && (cnt_q == 24'd1) && !wr_period;
        scroll_clr = !scroll_q || (wr_ctrl && !writedata[CTRL_SCROLL]);
        rot_step   = dir_q ? ((rot_q == '0) ? ROT_MAX : rot_q - 1'b1)
                           : ((rot_q == ROT_MAX) ? '0 : rot_q + 1'b1);
        value_d    = wr_value ? writedata[VW-1:0] : value_q;
        blank_d    = wr_mask ? writedata[DIGITS-1:0] : blank_q;
        blink_d    = wr_mask ? writedata[MASK_BLINK +: DIGITS] : blink_q;
        scroll_d   = wr_ctrl ? writedata[CTRL_SCROLL] : scroll_q;
        dir_d      = wr_ctrl ? writedata[CTRL_DIR] : dir_q;
        blink_en_d = wr_ctrl ? writedata[CTRL_BLINK] : blink_en_q;
        period_d   = wr_period ? writedata[23:0] : period_q;
        cnt_d      = wr_period ? writedata[23:0] :
                     (period_q == '0) ? cnt_q :
                     (cnt_q == 24'd1) ? period_q : cnt_q - 24'd1;
        rot_d      = scroll_clr ? '0 : tick ? rot_step : rot_q;
        phase_d    = blink_en_q && (phase_q ^ tick);
        hex_d      = '1;
        for (int i = 0; i < DIGITS; i++)
            hex_d[7*i +: 7] = (blank_q[i] || (blink_en_q && blink_q[i] && phase_q)) ? SEG_BLANK : seg[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q    <= '0;
            blank_q    <= '0;
            blink_q    <= '0;
            scroll_q   <= 1'b0;
            dir_q      <= 1'b0;
            blink_en_q <= 1'b0;
            period_q   <= PERIOD_RST;
            cnt_q      <= PERIOD_RST;
            rot_q      <= '0;
            phase_q    <= 1'b0;
            hex_q      <= '1;
        end else begin
            value_q    <= value_d;
            blank_q    <= blank_d;
            blink_q    <= blink_d;
            scroll_q   <= scroll_d;
            dir_q      <= dir_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            rot_q      <= rot_d;
            phase_q    <= phase_d;
            hex_q      <= hex_d;
        end
    end

`ifdef NIOS2_HEX_SCHED_IRQ_EN
    logic irq_en_d, wrap_d, irq_q, irq_d;

    // A wrap set in the same cycle as a software clear takes priority.
    always_comb begin
        irq_en_d = wr_ctrl ? writedata[CTRL_IRQ_EN] : irq_en_q;
        wrap_d   = (tick && !scroll_clr && (dir_q ? rot_q == '0 : rot_q == ROT_MAX))
                 || (wrap_q && !(wr_ctrl && writedata[CTRL_WRAP]));
        irq_d    = wrap_q && irq_en_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            wrap_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            wrap_q   <= wrap_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign wrap_q   = 1'b0;
    assign irq_en_q = 1'b0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        mask_rd                         = '0;
        mask_rd[DIGITS-1:0]             = blank_q;
        mask_rd[MASK_BLINK +: DIGITS]   = blink_q;
        ctrl_rd                         = '0;
        ctrl_rd[CTRL_SCROLL]            = scroll_q;
        ctrl_rd[CTRL_DIR]               = dir_q;
        ctrl_rd[CTRL_BLINK]             = blink_en_q;
        ctrl_rd[CTRL_IRQ_EN]            = irq_en_q;
        ctrl_rd[CTRL_WRAP]              = wrap_q;
        readdata = (addr == ADDR_VALUE) ? 32'(value_q) :
                   (addr == ADDR_MASK)  ? mask_rd :
                   (addr == ADDR_CTRL)  ? ctrl_rd : 32'(period_q);
    end

    assign hex_out = hex_q;

endmodule

// File: tb/tb_nios2_hex_sched.sv
// tb_nios2_hex_sched: directed literal checks plus randomized register traffic
// compared every cycle against a behavioural display model.
module tb_nios2_hex_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [41:0] hex_out;
    logic        irq;

    int checks = 0;
    int errors = 0;

`ifdef NIOS2_HEX_SCHED_IRQ_EN
    localparam logic [31:0] CTRL_RIGHT = 32'h0000_0103;
`else
    localparam logic [31:0] CTRL_RIGHT = 32'h0000_0003;
`endif

    nios2_hex_sched dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .hex_out    (hex_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Behavioural model state
    logic [23:0] m_value, m_period, m_cnt;
    logic [5:0]  m_blank, m_blink;
    logic        m_scroll, m_dir, m_blinken, m_irqen, m_phase, m_wrap, m_irq;
    int          m_rot, m_nr;
    logic [41:0] m_hex;
    logic        m_w, m_tick, m_clr;

    always_comb begin
        m_w    = chipselect && !write_n;
        m_tick = (m_period != 0) && (m_cnt == 1) && !(m_w && address == 2'd3);
        m_clr  = !m_scroll || (m_w && address == 2'd2 && !writedata[0]);
        m_nr   = m_dir ? m_rot - 1 : m_rot + 1;
    end

    function automatic logic [41:0] show();
        logic [41:0] h;
        logic [3:0]  n;
        h = '1;
        for (int i = 0; i < 6; i++) begin
            n = 4'(m_value >> (4 * ((i + m_rot) % 6)));
            h[7*i +: 7] = (m_blank[i] || (m_blinken && m_blink[i] && m_phase)) ? 7'h7F : seg_tab[n];
        end
        return h;
    endfunction

    function automatic logic [31:0] rd_exp(input logic [1:0] a);
        case (a)
            2'd0:    return {8'h0, m_value};
            2'd1:    return {18'h0, m_blink, 2'b00, m_blank};
            2'd2:    return {15'h0, m_wrap, 7'h0, m_irqen, 5'h0, m_blinken, m_dir, m_scroll};
            default: return {8'h0, m_period};
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_value <= 0; m_blank <= 0; m_blink <= 0;
            m_scroll <= 0; m_dir <= 0; m_blinken <= 0; m_irqen <= 0;
            m_period <= 24'd5000000; m_cnt <= 24'd5000000;
            m_rot <= 0; m_phase <= 0; m_hex <= '1; m_wrap <= 0; m_irq <= 0;
        end else begin
            m_hex <= show();
            if (m_w && address == 2'd3) m_cnt <= writedata[23:0];
            else if (m_period != 0) m_cnt <= (m_cnt == 1) ? m_period : m_cnt - 1;
            m_rot <= m_clr ? 0 : m_tick ? (m_nr + 6) % 6 : m_rot;
            m_phase <= m_blinken ? (m_phase ^ m_tick) : 1'b0;
`ifdef NIOS2_HEX_SCHED_IRQ_EN
            m_irq  <= m_wrap && m_irqen;
            m_wrap <= (m_tick && !m_clr && (m_nr < 0 || m_nr > 5))
                   || (m_wrap && !(m_w && address == 2'd2 && writedata[16]));
            if (m_w && address == 2'd2) m_irqen <= writedata[8];
`endif
            if (m_w && address == 2'd0) m_value <= writedata[23:0];
            if (m_w && address == 2'd1) begin
                m_blank <= writedata[5:0];
                m_blink <= writedata[13:8];
            end
            if (m_w && address == 2'd2) begin
                m_scroll  <= writedata[0];
                m_dir     <= writedata[1];
                m_blinken <= writedata[2];
            end
            if (m_w && address == 2'd3) m_period <= writedata[23:0];
        end
    end

    task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("hex_out", hex_out, m_hex);
        check("readdata", 42'(readdata), 42'(rd_exp(address)));
        check("irq", 42'(irq), 42'(m_irq));
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hex", hex_out, 42'h3FF_FFFF_FFFF);
        address = 2'd3; #1 check("reset_period", 42'(readdata), 42'd5000000);
        for (int a = 0; a < 3; a++) begin
            address = 2'(a); #1 check("reset_reg", 42'(readdata), 42'd0);
        end
        reset_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("release_d0", 42'(hex_out[6:0]), 42'(7'b1000000));
        #1;

        wr(2'd0, 32'h0012_345F);
        @(posedge clk); @(negedge clk);
        check("value_d0", 42'(hex_out[6:0]), 42'(7'b0001110));
        check("value_d5", 42'(hex_out[41:35]), 42'(7'b1111001));
        address = 2'd0; #1 check("value_rd", 42'(readdata), 42'h0012_345F);

        // Left scroll, period 4
        wr(2'd2, 32'h1); wr(2'd0, 32'h0054_3210); wr(2'd3, 32'd4);
        repeat (5) @(posedge clk); @(negedge clk);
        check("left_tick1", 42'(hex_out[6:0]), 42'(7'b1111001));
        repeat (20) @(posedge clk); @(negedge clk);
        check("left_wrap", 42'(hex_out[6:0]), 42'(7'b1000000));
        #1;

        // CTRL=0 written on a tick cycle wins
        wr(2'd2, 32'h0); wr(2'd2, 32'h1); wr(2'd3, 32'd4);
        repeat (3) @(posedge clk); #1;
        wr(2'd2, 32'h0);
        @(posedge clk); @(negedge clk);
        check("ctrl_on_tick", 42'(hex_out[6:0]), 42'(7'b1000000));
        #1;

        // PERIOD=0 freezes rotation
        wr(2'd2, 32'h1); wr(2'd3, 32'd4);
        repeat (5) @(posedge clk); @(negedge clk);
        check("freeze_pre", 42'(hex_out[6:0]), 42'(7'b1111001));
        #1;
        wr(2'd3, 32'd0);
        repeat (20) @(posedge clk); @(negedge clk);
        check("freeze_hold", 42'(hex_out[6:0]), 42'(7'b1111001));
        #1;

        // Right scroll
        wr(2'd2, 32'h0); wr(2'd2, CTRL_RIGHT); wr(2'd3, 32'd4);
        repeat (5) @(posedge clk); @(negedge clk);
        check("right_tick1", 42'(hex_out[6:0]), 42'(7'b0010010));
`ifdef NIOS2_HEX_SCHED_IRQ_EN
        check("irq_set", 42'(irq), 42'd1);
        address = 2'd2; #1 check("wrap_rd", 42'(readdata[16]), 42'd1);
        wr(2'd2, 32'h0001_0103);
        @(posedge clk); @(negedge clk);
        check("irq_clr", 42'(irq), 42'd0);
`endif
        #1;

        // Blank digit0, blink digit1
        wr(2'd2, 32'h0); wr(2'd1, 32'h0000_0201); wr(2'd2, 32'h4); wr(2'd3, 32'd3);
        repeat (2) @(posedge clk); @(negedge clk);
        check("blank_d0_a", 42'(hex_out[6:0]), 42'h7F);
        check("blink_on", 42'(hex_out[13:7]), 42'(7'b1111001));
        repeat (3) @(posedge clk); @(negedge clk);
        check("blank_d0_b", 42'(hex_out[6:0]), 42'h7F);
        check("blink_off", 42'(hex_out[13:7]), 42'h7F);
        repeat (3) @(posedge clk); @(negedge clk);
        check("blink_on2", 42'(hex_out[13:7]), 42'(7'b1111001));

        // Reset mid-blink blanks immediately
        #1 reset_n = 1'b0;
        #1 check("reset_async", hex_out, 42'h3FF_FFFF_FFFF);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = 1'($urandom_range(0, 1));
            writedata  = $urandom;
            if (address == 2'd3) writedata = $urandom_range(0, 9);
            if (address == 2'd2) writedata = $urandom & 32'h0001_0107;
            if (c == 2000) begin
                reset_n = 1'b0;
                @(posedge clk); #1;
                reset_n = 1'b1;
            end
        end
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
